// File: rtl/systolic_input_skew.sv
// Input skew feeder for a weight-stationary systolic array: lane k is delayed by k wavefronts.
// Optional SKEW_STALL_COUNT_EN adds STALL_COUNT, a saturating count of input bubbles while streaming.
module systolic_input_skew #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 256
) (
    input  logic                      CLK,
    input  logic                      ASYNC_RST,
    input  logic                      SYNC_RST,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic                      IN_LAST,
    input  logic [WIDTH*LENGTH-1:0]   IN_VECTOR,
    output logic [WIDTH*LENGTH-1:0]   OUT_VECTOR,
    output logic                      OUT_EN,
    output logic                      DONE
`ifdef SKEW_STALL_COUNT_EN
    ,
    output logic [15:0]               STALL_COUNT
`endif
);

    localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(LENGTH - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CW-1:0]            r_cnt;
    logic [CW-1:0]            w_cnt_next;
    logic                     r_en;
    logic                     r_done;
    logic                     w_accept;
    logic                     w_advance;
    logic                     w_done_next;
    logic [WIDTH*LENGTH-1:0]  w_feed;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        IN_READY     = (r_state != S_DRAIN);
        w_accept     = IN_VALID & IN_READY;
        w_advance    = w_accept;
        case (r_state)
            S_IDLE, S_STREAM: begin
                if (w_accept) begin
                    if (IN_LAST) begin
                        // A single-lane array has nothing to drain: the last beat ends the job.
                        if (LENGTH == 1) begin
                            w_state_next = S_IDLE;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next = S_DRAIN;
                            w_cnt_next   = DRAIN_LOAD;
                        end
                    end else begin
                        w_state_next = S_STREAM;
                    end
                end
            end
            S_DRAIN: begin
                w_advance  = 1'b1;
                w_cnt_next = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_feed = w_accept ? IN_VECTOR : '0;

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
        end else if (SYNC_RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_en    <= w_advance;
            r_done  <= w_done_next;
        end
    end

    assign OUT_EN = r_en;
    assign DONE   = r_done;

    // Lane gi: r_tap[0] takes the new element, r_tap[gi] drives the array, gi+1 registers total.
    genvar gi;
    generate
        for (gi = 0; gi < LENGTH; gi++) begin : g_lane
            logic [WIDTH-1:0] r_tap [0:gi];

            always_ff @(posedge CLK or posedge ASYNC_RST) begin
                if (ASYNC_RST) begin
                    for (int j = 0; j <= gi; j++) r_tap[j] <= '0;
                end else if (SYNC_RST) begin
                    for (int j = 0; j <= gi; j++) r_tap[j] <= '0;
                end else if (w_advance) begin
                    r_tap[0] <= w_feed[WIDTH*LENGTH-1-gi*WIDTH -: WIDTH];
                    for (int j = 1; j <= gi; j++) r_tap[j] <= r_tap[j-1];
                end
            end

            assign OUT_VECTOR[WIDTH*LENGTH-1-gi*WIDTH -: WIDTH] = r_tap[gi];
        end
    endgenerate

`ifdef SKEW_STALL_COUNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            r_stall <= '0;
        end else if (SYNC_RST) begin
            r_stall <= '0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_stall <= '0;
        end else if (r_state == S_STREAM && !IN_VALID && r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign STALL_COUNT = r_stall;
`endif

endmodule

// File: tb/tb_systolic_input_skew.sv
// Self-checking bench for systolic_input_skew (LENGTH=4 main instance, LENGTH=1 corner instance).
module tb_systolic_input_skew;

    localparam int W = 8;
    localparam int L = 4;
    localparam int N = W * L;

    localparam logic [N-1:0] V0 = 32'h01020304;
    localparam logic [N-1:0] V1 = 32'h11121314;
    localparam logic [N-1:0] V2 = 32'h21222324;

    logic         CLK = 1'b0;
    logic         ASYNC_RST;
    logic         SYNC_RST;
    logic         IN_VALID;
    logic         IN_READY;
    logic         IN_LAST;
    logic [N-1:0] IN_VECTOR;
    logic [N-1:0] OUT_VECTOR;
    logic         OUT_EN;
    logic         DONE;

    logic         v1, r1, l1, en1, done1;
    logic [W-1:0] vec1, o1;

`ifdef SKEW_STALL_COUNT_EN
    logic [15:0]  stall_count;
    logic [15:0]  stall1;
`endif

    always #5 CLK = ~CLK;

    systolic_input_skew #(.WIDTH(W), .LENGTH(L)) dut (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LAST(IN_LAST),
        .IN_VECTOR(IN_VECTOR), .OUT_VECTOR(OUT_VECTOR), .OUT_EN(OUT_EN), .DONE(DONE)
`ifdef SKEW_STALL_COUNT_EN
        , .STALL_COUNT(stall_count)
`endif
    );

    systolic_input_skew #(.WIDTH(W), .LENGTH(1)) dut1 (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST),
        .IN_VALID(v1), .IN_READY(r1), .IN_LAST(l1),
        .IN_VECTOR(vec1), .OUT_VECTOR(o1), .OUT_EN(en1), .DONE(done1)
`ifdef SKEW_STALL_COUNT_EN
        , .STALL_COUNT(stall1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: every advance appends its input wavefront (zeros for drain) to hist;
    // lane k of the output is lane k of the entry k advances back.
    logic [N-1:0] hist[$];
    int           drain_left;
    logic         exp_ready, exp_en, exp_done, obs_ready;
    logic [N-1:0] exp_vec;

    function automatic logic [N-1:0] model_wave();
        logic [N-1:0] r;
        logic [N-1:0] h;
        int idx;
        r = '0;
        for (int k = 0; k < L; k++) begin
            idx = hist.size() - 1 - k;
            if (idx >= 0) begin
                h = hist[idx];
                r[N-1-k*W -: W] = h[N-1-k*W -: W];
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        drain_left = 0;
        exp_vec    = '0;
    endtask

    // Drives one cycle; called right after a rising edge (+1), returns at the next edge +1.
    task automatic cyc(input logic v, input logic last, input logic [N-1:0] vec);
        IN_VALID  = v;
        IN_LAST   = last;
        IN_VECTOR = vec;
        @(negedge CLK);
        obs_ready = IN_READY;
        exp_ready = (drain_left == 0);
        exp_en    = 1'b0;
        exp_done  = 1'b0;
        if (v && exp_ready) begin
            hist.push_back(vec);
            exp_en = 1'b1;
            if (last) begin
                if (L == 1) exp_done = 1'b1;
                else        drain_left = L - 1;
            end
        end else if (drain_left > 0) begin
            hist.push_back('0);
            exp_en = 1'b1;
            drain_left--;
            if (drain_left == 0) exp_done = 1'b1;
        end
        exp_vec = model_wave();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        ASYNC_RST = 1'b1; SYNC_RST = 1'b0;
        IN_VALID = 1'b0; IN_LAST = 1'b0; IN_VECTOR = '0;
        v1 = 1'b0; l1 = 1'b0; vec1 = '0;
        model_reset();
        #1;
        n_vec++;
        if ({OUT_EN, DONE, OUT_VECTOR} !== {1'b0, 1'b0, {N{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%b done=%b vec=%h want 0 0 0", OUT_EN, DONE, OUT_VECTOR);
        end
        n_vec++;
        if ({en1, done1, o1} !== {1'b0, 1'b0, {W{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_outputs_l1: got en=%b done=%b vec=%h want 0 0 0", en1, done1, o1);
        end
        @(posedge CLK);
        @(negedge CLK);
        ASYNC_RST = 1'b0;
        @(posedge CLK);
        #1;
        n_vec++;
        if ({IN_READY, r1, OUT_EN} !== 3'b110) begin
            n_err++;
            $display("FAIL reset_ready: got rdy=%b rdy1=%b en=%b want 1 1 0", IN_READY, r1, OUT_EN);
        end
    endtask

    task automatic test_single_job();
        logic [N-1:0] tbl [6];
        logic [N-1:0] got[$];
        logic [N-1:0] vec;
        tbl = '{32'h01000000, 32'h11020000, 32'h21120300, 32'h00221304, 32'h00002314, 32'h00000024};
        for (int i = 0; i < 7; i++) begin
            vec = (i == 0) ? V0 : (i == 1) ? V1 : (i == 2) ? V2 : N'($urandom);
            cyc(i < 3, i == 2, vec);
            if (OUT_EN) got.push_back(OUT_VECTOR);
            n_vec++;
            if ({obs_ready, OUT_EN, DONE, OUT_VECTOR} !== {exp_ready, exp_en, exp_done, exp_vec}) begin
                n_err++;
                $display("FAIL single_job cyc%0d: got rdy=%b en=%b done=%b vec=%h want rdy=%b en=%b done=%b vec=%h",
                         i, obs_ready, OUT_EN, DONE, OUT_VECTOR, exp_ready, exp_en, exp_done, exp_vec);
            end
        end
        n_vec++;
        if (got.size() != 6) begin
            n_err++;
            $display("FAIL single_job_count: got %0d wavefronts want 6", got.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_vec++;
                if (got[k] !== tbl[k]) begin
                    n_err++;
                    $display("FAIL single_job_wave%0d: got %h want %h", k, got[k], tbl[k]);
                end
            end
        end
    endtask

    task automatic test_bubble();
        logic [N-1:0] vec;
        logic         v;
        for (int i = 0; i < 9; i++) begin
            v   = (i == 0) || (i == 3) || (i == 4);
            vec = (i == 0) ? V0 : (i == 3) ? V1 : (i == 4) ? V2 : N'($urandom);
            cyc(v, i == 4, vec);
            n_vec++;
            if ({obs_ready, OUT_EN, DONE, OUT_VECTOR} !== {exp_ready, exp_en, exp_done, exp_vec}) begin
                n_err++;
                $display("FAIL bubble cyc%0d: got rdy=%b en=%b done=%b vec=%h want rdy=%b en=%b done=%b vec=%h",
                         i, obs_ready, OUT_EN, DONE, OUT_VECTOR, exp_ready, exp_en, exp_done, exp_vec);
            end
            if (i == 1 || i == 2) begin
                n_vec++;
                if ({OUT_EN, OUT_VECTOR} !== {1'b0, 32'h01000000}) begin
                    n_err++;
                    $display("FAIL bubble_hold cyc%0d: got en=%b vec=%h want en=0 vec=01000000", i, OUT_EN, OUT_VECTOR);
                end
            end
        end
`ifdef SKEW_STALL_COUNT_EN
        n_vec++;
        if (stall_count !== 16'd2) begin
            n_err++;
            $display("FAIL stall_count_after_job: got %0d want 2", stall_count);
        end
`endif
    endtask

    task automatic test_single_beat_back_to_back();
        logic [N-1:0] vec;
        logic         v;
        for (int i = 0; i < 9; i++) begin
            v   = (i == 0) || (i == 4);
            vec = (i == 0) ? V0 : N'($urandom);
            cyc(v, v, vec);
`ifdef SKEW_STALL_COUNT_EN
            if (i == 0) begin
                n_vec++;
                if (stall_count !== 16'd0) begin
                    n_err++;
                    $display("FAIL stall_count_clear: got %0d want 0", stall_count);
                end
            end
`endif
            n_vec++;
            if ({obs_ready, OUT_EN, DONE, OUT_VECTOR} !== {exp_ready, exp_en, exp_done, exp_vec}) begin
                n_err++;
                $display("FAIL single_beat cyc%0d: got rdy=%b en=%b done=%b vec=%h want rdy=%b en=%b done=%b vec=%h",
                         i, obs_ready, OUT_EN, DONE, OUT_VECTOR, exp_ready, exp_en, exp_done, exp_vec);
            end
            if (i == 3) begin
                n_vec++;
                if ({OUT_EN, DONE, OUT_VECTOR} !== {2'b11, 32'h00000004}) begin
                    n_err++;
                    $display("FAIL single_beat_last: got en=%b done=%b vec=%h want 1 1 00000004", OUT_EN, DONE, OUT_VECTOR);
                end
            end
            if (i == 4) begin
                n_vec++;
                if ({obs_ready, OUT_EN} !== 2'b11) begin
                    n_err++;
                    $display("FAIL back_to_back_accept: got rdy=%b en=%b want 1 1", obs_ready, OUT_EN);
                end
            end
        end
    endtask

    task automatic test_async_reset_mid_drain();
        logic [N-1:0] vec;
        for (int i = 0; i < 4; i++) begin
            vec = (i == 0) ? V0 : (i == 1) ? V1 : V2;
            cyc(i < 3, i == 2, vec);
        end
        n_vec++;
        if ({OUT_EN, OUT_VECTOR} !== {1'b1, 32'h00221304}) begin
            n_err++;
            $display("FAIL pre_abort_wave: got en=%b vec=%h want 1 00221304", OUT_EN, OUT_VECTOR);
        end
        #2;
        ASYNC_RST = 1'b1;
        #1;
        n_vec++;
        if ({OUT_EN, DONE, OUT_VECTOR} !== {2'b00, {N{1'b0}}}) begin
            n_err++;
            $display("FAIL async_abort: got en=%b done=%b vec=%h want 0 0 0", OUT_EN, DONE, OUT_VECTOR);
        end
        @(negedge CLK);
        @(negedge CLK);
        ASYNC_RST = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, N'($urandom));
            n_vec++;
            if ({obs_ready, OUT_EN, DONE, OUT_VECTOR} !== {exp_ready, exp_en, exp_done, exp_vec}) begin
                n_err++;
                $display("FAIL after_abort cyc%0d: got rdy=%b en=%b done=%b vec=%h want rdy=%b en=%b done=%b vec=%h",
                         i, obs_ready, OUT_EN, DONE, OUT_VECTOR, exp_ready, exp_en, exp_done, exp_vec);
            end
        end
    endtask

    task automatic test_sync_reset();
        cyc(1'b1, 1'b0, V0);
        cyc(1'b1, 1'b0, V1);
        IN_VALID  = 1'b1;
        IN_LAST   = 1'b1;
        IN_VECTOR = V2;
        SYNC_RST  = 1'b1;
        @(posedge CLK);
        #1;
        SYNC_RST = 1'b0;
        model_reset();
        n_vec++;
        if ({IN_READY, OUT_EN, DONE, OUT_VECTOR} !== {3'b100, {N{1'b0}}}) begin
            n_err++;
            $display("FAIL sync_reset: got rdy=%b en=%b done=%b vec=%h want 1 0 0 0", IN_READY, OUT_EN, DONE, OUT_VECTOR);
        end
    endtask

    task automatic test_random();
        int beats_left;
        int budget;
        logic v, last, will_accept;
        budget = 2000;
        for (int job = 0; job < 12; job++) begin
            beats_left = $urandom_range(1, 6);
            while ((beats_left > 0 || drain_left > 0) && budget > 0) begin
                budget--;
                v           = ($urandom_range(0, 3) != 0);
                will_accept = v && (drain_left == 0);
                last        = will_accept ? (beats_left == 1) : 1'($urandom);
                cyc(v, last, N'($urandom));
                if (will_accept) beats_left--;
                n_vec++;
                if ({obs_ready, OUT_EN, DONE, OUT_VECTOR} !== {exp_ready, exp_en, exp_done, exp_vec}) begin
                    n_err++;
                    $display("FAIL random job%0d: got rdy=%b en=%b done=%b vec=%h want rdy=%b en=%b done=%b vec=%h",
                             job, obs_ready, OUT_EN, DONE, OUT_VECTOR, exp_ready, exp_en, exp_done, exp_vec);
                end
            end
        end
        n_vec++;
        if (budget == 0) begin
            n_err++;
            $display("FAIL random_budget: got budget=%0d want >0", budget);
        end
    endtask

    task automatic test_length1();
        logic [W-1:0] val;
        for (int i = 0; i < 5; i++) begin
            val  = (i == 0) ? 8'hAA : W'($urandom);
            v1   = 1'b1;
            l1   = 1'b1;
            vec1 = val;
            @(negedge CLK);
            n_vec++;
            if (r1 !== 1'b1) begin
                n_err++;
                $display("FAIL len1_ready%0d: got %b want 1", i, r1);
            end
            @(posedge CLK);
            #1;
            v1 = 1'b0;
            vec1 = W'($urandom);
            n_vec++;
            if ({en1, done1, o1} !== {2'b11, val}) begin
                n_err++;
                $display("FAIL len1_wave%0d: got en=%b done=%b vec=%h want 1 1 %h", i, en1, done1, o1, val);
            end
            @(posedge CLK);
            #1;
            n_vec++;
            if ({r1, en1, done1, o1} !== {3'b100, val}) begin
                n_err++;
                $display("FAIL len1_idle%0d: got rdy=%b en=%b done=%b vec=%h want 1 0 0 %h", i, r1, en1, done1, o1, val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_bubble();
        test_single_beat_back_to_back();
        test_async_reset_mid_drain();
        test_sync_reset();
        test_random();
        test_length1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/systolic_input_skew.md
Name: systolic_input_skew

Overview:
- Upstream feeder for the weight-stationary systolic matrix-multiply array.
- Accepts one full input vector per beat over a valid/ready handshake.
- Delays lane k by k wavefronts so row k of the array sees its data k cycles after row 0.
- After the last vector of a job, drains LENGTH-1 zero wavefronts. Drives the array's INPUTS bus and EN.

Parameters:
- WIDTH, 8, bits per element.
- LENGTH, 256, number of lanes; equals the array dimension; must be >= 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- ASYNC_RST  input  1  asynchronous reset, active-high.
- SYNC_RST  input  1  synchronous clear, active-high; same effect as ASYNC_RST, taken at the clock edge.
- IN_VALID  input  1  IN_VECTOR/IN_LAST are valid.
- IN_READY  output  1  block can accept a beat.
- IN_LAST  input  1  marks the final vector of a job.
- IN_VECTOR  input  WIDTH*LENGTH  lane k at bits [WIDTH*LENGTH-1-k*WIDTH : WIDTH*LENGTH-(k+1)*WIDTH]; lane 0 is MSB-first.
- OUT_VECTOR  output  WIDTH*LENGTH  skewed wavefront to the array INPUTS; same lane packing as IN_VECTOR.
- OUT_EN  output  1  array EN; high for exactly the cycles in which OUT_VECTOR holds a new wavefront.
- DONE  output  1  one-cycle pulse coinciding with the final drain wavefront.

Behaviour:
- Reset (either reset):
  - all skew registers and OUT_VECTOR = 0; OUT_EN = 0; DONE = 0; state = IDLE.
  - IN_READY = 1 once reset deasserts.
  - Reset mid-job aborts it: no DONE pulse, all partial data discarded.
- Skew structure:
  - Lane k is a k-deep shift chain plus one output register (k+1 registers in total).
  - All chains shift together only on an "advance" edge.
  - On each advance:
    - lane 0's output register loads the new lane-0 element;
    - lane k's chain input loads the new lane-k element;
    - every lane k output shows the element accepted k advances earlier.
- Advance source:
  - An accepted beat (IN_VALID & IN_READY) supplies IN_VECTOR.
  - A drain cycle supplies all zeros.
  - With no advance, all skew registers hold, which preserves alignment across bubbles.
- OUT_EN is a register, set to 1 on the cycle following each advance and 0 otherwise.
- Latency: lane 0 of beat n appears one cycle after acceptance. Lane k appears on the cycle after the k-th subsequent advance.
- FSM:
  - IDLE: IN_READY=1.
    - Accept with IN_LAST=0 -> STREAM.
    - Accept with IN_LAST=1 -> DRAIN, or finish immediately if LENGTH=1.
  - STREAM: IN_READY=1.
    - Bubbles are allowed (no advance).
    - Accept with IN_LAST=1 -> DRAIN and load drain counter with LENGTH-1.
  - DRAIN: IN_READY=0.
    - Advances every cycle with zero data and decrements the counter.
    - The advance that brings the counter to 0 -> IDLE.
- Drain counter width: $clog2(LENGTH) bits, minimum 1.
- DONE timing:
  - Registered and asserted together with OUT_EN for the wavefront produced by the final advance of a job.
  - That is the last drain advance, or the IN_LAST accept when LENGTH=1.
- Back-to-back jobs: a new job can be accepted in the cycle DONE is high, because state is IDLE then.
- IN_VECTOR content is ignored when not accepted. IN_LAST is ignored unless the beat is accepted.
- SYNC_RST overrides any advance in the same cycle.

Optional Feature:
- Macro: SKEW_STALL_COUNT_EN
- When defined:
  - Adds output STALL_COUNT [15:0].
  - Counts STREAM-state cycles in which IN_VALID=0, i.e. input bubbles.
  - Saturates at 16'hFFFF.
  - Cleared by either reset and on each IDLE->STREAM/DRAIN transition.
- When undefined: the port and counter do not exist; no other behaviour changes.

Test Plan:
- WIDTH=8, LENGTH=4, single job.
  - Stimulus: beats V0={01,02,03,04}, V1={11,12,13,14}, V2={21,22,23,24}(IN_LAST) on consecutive cycles.
  - Required OUT_VECTOR on successive OUT_EN cycles: {01,00,00,00}, {11,02,00,00}, {21,12,03,00}, {00,22,13,04}, {00,00,23,14}, {00,00,00,24}.
  - DONE is high only on the last of these; IN_READY=0 for the 3 drain cycles.
- Same job with 2 idle cycles inserted between V0 and V1.
  - The wavefront sequence is identical.
  - OUT_EN is low for 2 cycles, and OUT_VECTOR holds {01,00,00,00} during the gap.
- Single-beat job V0 with IN_LAST from IDLE.
  - 4 wavefronts are produced, ending {00,00,00,04}, with DONE high on it.
  - A new job beat is accepted on the DONE cycle.
- ASYNC_RST asserted mid-drain (after wavefront 4 of the first scenario).
  - OUT_VECTOR=0, OUT_EN=0 immediately (not waiting for a clock edge).
  - No DONE pulse; IN_READY=1 after release.
- LENGTH=1.
  - Stimulus: beat AA with IN_LAST.
  - One wavefront {AA} with OUT_EN=1 and DONE=1 in the same cycle; no drain, IN_READY stays 1.
- SKEW_STALL_COUNT_EN defined, bubble scenario above.
  - STALL_COUNT=2 after the job.
  - Cleared to 0 when the next job's first beat is accepted.
